// File: rtl/vmem_seq_if.sv
// Bank-side bus of the vector load/store sequencer.
// master: the sequencer (drives start/rw/addr/din); slave: the memory bank.
interface vmem_seq_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
);
  logic          bank_start;
  logic          bank_rw;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_din;
  logic [DW-1:0] bank_dout;
  logic          bank_ready;
  logic          bank_done;

  modport master (
    output bank_start, bank_rw, bank_addr, bank_din,
    input  bank_dout, bank_ready, bank_done
  );

  modport slave (
    input  bank_start, bank_rw, bank_addr, bank_din,
    output bank_dout, bank_ready, bank_done
  );
endinterface

// File: rtl/vmem_seq.sv
// Strided vector load/store sequencer in front of a single memory bank.
// One command (base, stride, vl) is expanded into vl bank accesses, strictly in
// element order with at most one access outstanding. Stores scatter the latched
// operand; loads gather into vout.
// Optional build macro VMEM_TIMEOUT_EN adds a per-element watchdog that aborts a
// stalled command and raises a sticky err flag.
module vmem_seq #(
  parameter int unsigned VLMAX = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 6,
  parameter int unsigned VLW   = 4,
  parameter int unsigned TMO   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rw,
  input  logic [AW-1:0]       cmd_base,
  input  logic [AW-1:0]       cmd_stride,
  input  logic [VLW-1:0]      cmd_vl,
  input  logic [VLMAX*DW-1:0] vin,
  output logic [VLMAX*DW-1:0] vout,
  output logic                seq_done,
  output logic                busy,
  output logic                err,
  vmem_seq_if.master          bank
);

  // Parameter sanity: cmd_vl must be able to hold VLMAX, watchdog limit non-zero.
  if (VLMAX == 0 || VLMAX >= (1 << VLW) || TMO == 0) begin : g_bad_params
    $error("vmem_seq: inconsistent parameters");
  end

  localparam logic [VLW-1:0] VlMax = VLW'(VLMAX);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFinish} state_e;

  state_e                state_q, state_d;
  logic                  rw_q, rw_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [AW-1:0]         stride_q, stride_d;
  logic [VLW-1:0]        vl_q, vl_d;
  logic [VLW-1:0]        idx_q, idx_d;
  logic [VLMAX*DW-1:0]   vin_q, vin_d;
  logic [VLMAX*DW-1:0]   vout_q, vout_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  seq_done_q, seq_done_d;
  logic                  busy_q, busy_d;
  logic                  bank_start_q, bank_start_d;
  logic                  bank_rw_q, bank_rw_d;
  logic [AW-1:0]         bank_addr_q, bank_addr_d;
  logic [DW-1:0]         bank_din_q, bank_din_d;

  logic [VLW-1:0]        vl_clamped;
  logic [VLW-1:0]        idx_next;
  logic [DW-1:0]         vin_elem;

`ifdef VMEM_TIMEOUT_EN
  localparam int unsigned TcW = $clog2(TMO + 1);
  logic [TcW-1:0]        tmo_q, tmo_d;
  logic                  err_q, err_d;
`endif

  assign vl_clamped = (cmd_vl > VlMax) ? VlMax : cmd_vl;
  assign idx_next   = idx_q + VLW'(1);

  // Select store operand element idx_q.
  always_comb begin
    vin_elem = '0;
    for (int e = 0; e < VLMAX; e++) begin
      if (idx_q == VLW'(e)) vin_elem = vin_q[e*DW +: DW];
    end
  end

  // Next-state and registered-output logic of the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    stride_d     = stride_q;
    vl_d         = vl_q;
    idx_d        = idx_q;
    vin_d        = vin_q;
    vout_d       = vout_q;
    cmd_ready_d  = cmd_ready_q;
    seq_done_d   = 1'b0;
    busy_d       = busy_q;
    bank_start_d = 1'b0;
    bank_rw_d    = bank_rw_q;
    bank_addr_d  = bank_addr_q;
    bank_din_d   = bank_din_q;
`ifdef VMEM_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = err_q;
`endif

    case (state_q)
      StIdle: begin
        // cmd_ready rises one cycle after the seq_done pulse.
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          rw_d        = cmd_rw;
          addr_d      = cmd_base;
          stride_d    = cmd_stride;
          vl_d        = vl_clamped;
          vin_d       = vin;
          idx_d       = '0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = (vl_clamped == '0) ? StFinish : StIssue;
        end
      end

      StIssue: begin
        if (bank.bank_ready) begin
          bank_start_d = 1'b1;
          bank_rw_d    = rw_q;
          bank_addr_d  = addr_q;
          if (rw_q) bank_din_d = vin_elem;
`ifdef VMEM_TIMEOUT_EN
          tmo_d        = '0;
`endif
          state_d      = StWait;
        end
      end

      StWait: begin
        // bank_ready is deliberately ignored: it stays high one cycle after start.
        if (bank.bank_done) begin
          if (!rw_q) begin
            for (int e = 0; e < VLMAX; e++) begin
              if (idx_q == VLW'(e)) vout_d[e*DW +: DW] = bank.bank_dout;
            end
          end
          idx_d   = idx_next;
          addr_d  = addr_q + stride_q;
          state_d = (idx_next == vl_q) ? StFinish : StIssue;
        end
`ifdef VMEM_TIMEOUT_EN
        else if (tmo_q == TcW'(TMO - 1)) begin
          // Abort: remaining elements are skipped, gathered elements are kept.
          err_d      = 1'b1;
          seq_done_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end else begin
          tmo_d = tmo_q + TcW'(1);
        end
`endif
      end

      StFinish: begin
        seq_done_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      stride_q     <= '0;
      vl_q         <= '0;
      idx_q        <= '0;
      vin_q        <= '0;
      vout_q       <= '0;
      cmd_ready_q  <= 1'b1;
      seq_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      bank_start_q <= 1'b0;
      bank_rw_q    <= 1'b0;
      bank_addr_q  <= '0;
      bank_din_q   <= '0;
`ifdef VMEM_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      stride_q     <= stride_d;
      vl_q         <= vl_d;
      idx_q        <= idx_d;
      vin_q        <= vin_d;
      vout_q       <= vout_d;
      cmd_ready_q  <= cmd_ready_d;
      seq_done_q   <= seq_done_d;
      busy_q       <= busy_d;
      bank_start_q <= bank_start_d;
      bank_rw_q    <= bank_rw_d;
      bank_addr_q  <= bank_addr_d;
      bank_din_q   <= bank_din_d;
`ifdef VMEM_TIMEOUT_EN
      tmo_q        <= tmo_d;
      err_q        <= err_d;
`endif
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign seq_done        = seq_done_q;
  assign busy            = busy_q;
  assign vout            = vout_q;
  assign bank.bank_start = bank_start_q;
  assign bank.bank_rw    = bank_rw_q;
  assign bank.bank_addr  = bank_addr_q;
  assign bank.bank_din   = bank_din_q;

`ifdef VMEM_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vmem_seq.sv
// Scoreboard bench for vmem_seq: the driver pushes hand-computed bank accesses
// and completion records; a negedge monitor pops and compares them.
module tb_vmem_seq;
  localparam int unsigned VLMAX = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;
  localparam int unsigned VLW   = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_rw = 1'b0;
  logic [AW-1:0]       cmd_base = '0;
  logic [AW-1:0]       cmd_stride = '0;
  logic [VLW-1:0]      cmd_vl = '0;
  logic [VLMAX*DW-1:0] vin = '0;
  logic [VLMAX*DW-1:0] vout;
  logic                seq_done, busy, err;

  vmem_seq_if #(.DW(DW), .AW(AW)) bus ();

  vmem_seq #(.VLMAX(VLMAX), .DW(DW), .AW(AW), .VLW(VLW), .TMO(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rw     (cmd_rw),
    .cmd_base   (cmd_base),
    .cmd_stride (cmd_stride),
    .cmd_vl     (cmd_vl),
    .vin        (vin),
    .vout       (vout),
    .seq_done   (seq_done),
    .busy       (busy),
    .err        (err),
    .bank       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // ---------------- bank model: 3 phases after start, done on the 4th cycle ----
  logic [DW-1:0] mem [64] = '{default: '0};
  logic          active = 1'b0;
  int            ph = 0;
  logic          lat_rw;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_din;
  logic          hold_done = 1'b0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (reset) begin
      active         <= 1'b0;
      ph             <= 0;
      bus.bank_done  <= 1'b0;
      bus.bank_ready <= 1'b1;
      bus.bank_dout  <= '0;
    end else if (!active) begin
      bus.bank_done <= 1'b0;
      if (bus.bank_start) begin
        active   <= 1'b1;
        ph       <= 0;
        lat_rw   <= bus.bank_rw;
        lat_addr <= bus.bank_addr;
        lat_din  <= bus.bank_din;
      end
    end else begin
      ph <= ph + 1;
      if (ph == 0) bus.bank_ready <= 1'b0;
      if (ph == 1 && !hold_done) begin
        bus.bank_done <= 1'b1;
        if (lat_rw) mem[lat_addr] <= lat_din;
        else        bus.bank_dout <= mem[lat_addr];
      end
      if (ph == 2) begin
        bus.bank_done  <= 1'b0;
        bus.bank_ready <= 1'b1;
        active         <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } acc_t;

  typedef struct {
    logic [255:0] vout;
    int           delta;
    int           acc;
    logic         err;
  } done_t;

  acc_t  exp_acc[$];
  done_t exp_done[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.bank_start) begin
        if (exp_acc.size() == 0) begin
          fail("unexpected_bank_start");
        end else begin
          acc_t a;
          a = exp_acc.pop_front();
          chk("bank_rw", 256'(bus.bank_rw), 256'(a.rw));
          chk("bank_addr", 256'(bus.bank_addr), 256'(a.addr));
          if (a.rw) chk("bank_din", 256'(bus.bank_din), 256'(a.din));
        end
      end
      if (seq_done) begin
        if (exp_done.size() == 0) begin
          fail("unexpected_seq_done");
        end else begin
          done_t d;
          d = exp_done.pop_front();
          chk("vout", vout, d.vout);
          chk("done_latency", 256'(cyc - d.acc), 256'(d.delta));
          chk("err_at_done", 256'(err), 256'(d.err));
          chk("busy_at_done", 256'(busy), 256'(0));
          chk("cmd_ready_at_done", 256'(cmd_ready), 256'(0));
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [255:0] pk(input logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  task automatic push_acc(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    acc_t a;
    a.rw = rw;
    a.addr = addr;
    a.din = din;
    exp_acc.push_back(a);
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    pre_we = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one command; returns at the negedge after the accept edge.
  task automatic issue_cmd(input logic rw, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input logic [VLW-1:0] vl, input logic [255:0] v,
                           input logic expect_done, input logic [255:0] exp_vout,
                           input int delta, input logic exp_err);
    int n = 0;
    done_t d;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail("cmd_ready_wait");
    cmd_valid = 1'b1;
    cmd_rw = rw;
    cmd_base = base;
    cmd_stride = stride;
    cmd_vl = vl;
    vin = v;
    if (expect_done) begin
      d.vout = exp_vout;
      d.delta = delta;
      d.acc = cyc;
      d.err = exp_err;
      exp_done.push_back(d);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_done.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_done.size() != 0) fail("seq_done_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_cmd_ready", 256'(cmd_ready), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_seq_done", 256'(seq_done), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_bank_start", 256'(bus.bank_start), 256'(0));
    chk("rst_bank_addr", 256'(bus.bank_addr), 256'(0));
    chk("rst_vout", vout, 256'(0));

    // Store 11,22,33,44 to 0..3, then load back.
    for (int i = 0; i < 4; i++) push_acc(1'b1, AW'(i), 32'((i + 1) * 11));
    issue_cmd(1'b1, 6'd0, 6'd1, 4'd4, pk(11, 22, 33, 44, 0, 0, 0, 0), 1'b1, '0, 22, 1'b0);
    wait_drain();
    for (int i = 0; i < 4; i++) push_acc(1'b0, AW'(i), '0);
    issue_cmd(1'b0, 6'd0, 6'd1, 4'd4, '0, 1'b1, pk(11, 22, 33, 44, 0, 0, 0, 0), 22, 1'b0);
    wait_drain();

    // Wrapping strided load: 62, 1, 4.
    preload(6'd62, 32'd5);
    preload(6'd1, 32'd6);
    preload(6'd4, 32'd7);
    push_acc(1'b0, 6'd62, '0);
    push_acc(1'b0, 6'd1, '0);
    push_acc(1'b0, 6'd4, '0);
    issue_cmd(1'b0, 6'd62, 6'd3, 4'd3, '0, 1'b1, pk(5, 6, 7, 44, 0, 0, 0, 0), 17, 1'b0);
    wait_drain();

    // vl=0: no bank access, done two cycles after accept, vout untouched.
    issue_cmd(1'b0, 6'd10, 6'd1, 4'd0, '0, 1'b1, pk(5, 6, 7, 44, 0, 0, 0, 0), 2, 1'b0);
    wait_drain();

    // Reset during WAIT of element 2 of an 8-element store.
    for (int i = 0; i < 3; i++) push_acc(1'b1, AW'(20 + i), 32'(101 + i));
    issue_cmd(1'b1, 6'd20, 6'd1, 4'd8, pk(101, 102, 103, 104, 105, 106, 107, 108),
              1'b0, '0, 0, 1'b0);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd_ready", 256'(cmd_ready), 256'(1));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_seq_done", 256'(seq_done), 256'(0));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_acc_left", 256'(exp_acc.size()), 256'(0));
    chk("mem20", 256'(mem[20]), 256'(101));
    chk("mem21", 256'(mem[21]), 256'(102));
    for (int i = 22; i < 28; i++) chk("mem_untouched", 256'(mem[i]), 256'(0));

    // stride=0 store: last element wins at address 9.
    push_acc(1'b1, 6'd9, 32'd1);
    push_acc(1'b1, 6'd9, 32'd2);
    push_acc(1'b1, 6'd9, 32'd3);
    issue_cmd(1'b1, 6'd9, 6'd0, 4'd3, pk(1, 2, 3, 0, 0, 0, 0, 0), 1'b1, '0, 17, 1'b0);
    wait_drain();
    push_acc(1'b0, 6'd9, '0);
    issue_cmd(1'b0, 6'd9, 6'd0, 4'd1, '0, 1'b1, pk(3, 0, 0, 0, 0, 0, 0, 0), 7, 1'b0);
    wait_drain();

    // cmd_vl above VLMAX clamps to 8 elements.
    for (int i = 0; i < 8; i++) push_acc(1'b0, AW'(i), '0);
    issue_cmd(1'b0, 6'd0, 6'd1, 4'd15, '0, 1'b1, pk(11, 6, 33, 44, 7, 0, 0, 0), 42, 1'b0);
    wait_drain();

`ifdef VMEM_TIMEOUT_EN
    // Bank never signals done: abort 16 cycles after the stalled start pulse.
    hold_done = 1'b1;
    push_acc(1'b1, 6'd40, 32'd77);
    issue_cmd(1'b1, 6'd40, 6'd1, 4'd2, pk(77, 88, 0, 0, 0, 0, 0, 0),
              1'b1, pk(11, 6, 33, 44, 7, 0, 0, 0), 18, 1'b1);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("err_sticky", 256'(err), 256'(1));
    chk("tmo_mem40", 256'(mem[40]), 256'(0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hold_done = 1'b0;
    chk("err_cleared", 256'(err), 256'(0));
`endif

    repeat (5) @(negedge clk);
    chk("acc_queue_empty", 256'(exp_acc.size()), 256'(0));
    chk("done_queue_empty", 256'(exp_done.size()), 256'(0));
    chk("final_err", 256'(err), 256'(0));
    chk("final_idle", 256'({busy, cmd_ready}), 256'(2'b01));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
